// File: rtl/sp_pkg.sv
// Shared pipeline types: architectural widths plus the writeback request and source encodings.
package sp_pkg;
   localparam int XLEN           = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [XLEN-1:0]           data;
   } wb_req_t;

   typedef enum logic {WB_SRC_LSU, WB_SRC_ALU} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback requests: head visible combinationally the cycle after the push.
// No internal backpressure; the producer must gate push with full and pop with empty.
module wb_fifo
   import sp_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int W     = REG_ADDR_WIDTH + XLEN,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             push_i,
   input  logic [W-1:0]     wr_dat_i,
   input  logic             pop_i,
   output logic [W-1:0]     rd_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] cnt_o
);
   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr] <= wr_dat_i;
   end

   assign rd_dat_o = mem[rd_ptr];
   assign full_o   = (cnt == CNT_W'(DEPTH));
   assign empty_o  = (cnt == '0);
   assign cnt_o    = cnt;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (arst_ni) begin
         assert (!(push_i && full_o && !pop_i)) else $error("wb_fifo: push while full");
         assert (!(pop_i && empty_o)) else $error("wb_fifo: pop while empty");
         assert ((DEPTH & (DEPTH - 1)) == 0 && DEPTH >= 2) else $error("wb_fifo: DEPTH not a power of two");
      end
   end
`endif
endmodule

// File: rtl/writeback_stage.sv
// Merges ALU and LSU results onto the register-file write port; LSU write 1 cycle, ALU >= 2 cycles.
// LSU is stalled only while the ALU buffer is full; the ALU is never stalled (full forces a pop).
module writeback_stage
   import sp_pkg::*;
#(
   parameter int ALU_FIFO_DEPTH = 2
) (
   input  logic                                clk_i,
   input  logic                                arst_ni,
   input  logic                                alu_valid_i,
   output logic                                alu_ready_o,
   input  logic                                alu_wen_i,
   input  logic [REG_ADDR_WIDTH-1:0]           alu_rd_addr_i,
   input  logic [XLEN-1:0]                     alu_rd_data_i,
   input  logic                                lsu_valid_i,
   output logic                                lsu_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0]           lsu_rd_addr_i,
   input  logic [XLEN-1:0]                     lsu_rd_data_i,
   output logic                                rd_en_o,
   output logic [REG_ADDR_WIDTH-1:0]           rd_addr_o,
   output logic [XLEN-1:0]                     rd_data_o,
   output logic [$clog2(ALU_FIFO_DEPTH+1)-1:0] alu_fifo_cnt_o
);
   wb_req_t fifo_head;
   wb_req_t alu_req;
   wb_req_t lsu_req;
   wb_req_t wr_req;
   wb_src_e wr_src;
   logic    wr_vld;
   logic    fifo_full;
   logic    fifo_empty;
   logic    fifo_push;
   logic    fifo_pop;

   assign alu_req = '{addr: alu_rd_addr_i, data: alu_rd_data_i};
   assign lsu_req = '{addr: lsu_rd_addr_i, data: lsu_rd_data_i};

   // LSU has priority, but a full buffer takes the port, so neither side can starve.
   always_comb begin
      wr_vld   = 1'b0;
      wr_src   = WB_SRC_LSU;
      fifo_pop = 1'b0;
      if (fifo_full) begin
         wr_vld   = 1'b1;
         wr_src   = WB_SRC_ALU;
         fifo_pop = 1'b1;
      end else if (lsu_valid_i) begin
         wr_vld = 1'b1;
         wr_src = WB_SRC_LSU;
      end else if (!fifo_empty) begin
         wr_vld   = 1'b1;
         wr_src   = WB_SRC_ALU;
         fifo_pop = 1'b1;
      end
   end

   assign lsu_ready_o = !fifo_full;
   assign alu_ready_o = !fifo_full || fifo_pop;
   assign fifo_push   = alu_valid_i && alu_ready_o && alu_wen_i;
   assign wr_req      = (wr_src == WB_SRC_ALU) ? fifo_head : lsu_req;

   wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_alu_fifo (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .push_i   (fifo_push),
      .wr_dat_i (alu_req),
      .pop_i    (fifo_pop),
      .rd_dat_o (fifo_head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .cnt_o    (alu_fifo_cnt_o)
   );

   // Writes to x0 still consume their slot but never assert the enable.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         rd_data_o <= '0;
      end else if (wr_vld) begin
         rd_en_o   <= |wr_req.addr;
         rd_addr_o <= wr_req.addr;
         rd_data_o <= wr_req.data;
      end else begin
         rd_en_o <= 1'b0;
      end
   end
endmodule
